// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle CPU: per-state datapath strobes, cycle/retire counters, MDU watchdog.
// Optional feature macro: MULTICYCLE_CTRL_EXC_EN enables the EXC state and CP0 writes.
module multicycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       inst_class,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             mdu_busy,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_write,
  output logic             ir_write,
  output logic             a_write,
  output logic             b_write,
  output logic             aluout_write,
  output logic             mdr_write,
  output logic             rf_write,
  output logic             wb_src,
  output logic [1:0]       pc_src,
  output logic             mdu_start,
  output logic             cp0_write,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             mdu_err
);

  localparam int unsigned WD_W = $clog2(MDU_TIMEOUT + 1);

  localparam logic [2:0] CL_ALU_R  = 3'd0;
  localparam logic [2:0] CL_ALU_I  = 3'd1;
  localparam logic [2:0] CL_LOAD   = 3'd2;
  localparam logic [2:0] CL_STORE  = 3'd3;
  localparam logic [2:0] CL_BRANCH = 3'd4;
  localparam logic [2:0] CL_JUMP   = 3'd5;
  localparam logic [2:0] CL_MDU    = 3'd6;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_MDW = 3'd5,
    S_EXC = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q;
  logic            retire;
  logic            wd_hit;

  // Next-state and strobe decode; while reset is asserted only imem_req is driven.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    wd_hit       = 1'b0;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    a_write      = 1'b0;
    b_write      = 1'b0;
    aluout_write = 1'b0;
    mdr_write    = 1'b0;
    rf_write     = 1'b0;
    wb_src       = 1'b0;
    pc_src       = 2'b00;
    mdu_start    = 1'b0;
    cp0_write    = 1'b0;
    if (!rst) begin
      imem_req = 1'b1;
      state_d  = S_IF;
    end else begin
      case (state_q)
        S_IF: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_ID;
          end
        end
        S_ID: begin
          a_write = 1'b1;
          b_write = 1'b1;
          state_d = S_EX;
        end
        S_EX: begin
          aluout_write = 1'b1;
          case (inst_class)
            CL_ALU_R, CL_ALU_I: state_d = S_WB;
            CL_LOAD, CL_STORE:  state_d = S_MEM;
            CL_BRANCH: begin
              pc_write = branch_taken;
              pc_src   = 2'b01;
              retire   = 1'b1;
              state_d  = S_IF;
            end
            CL_JUMP: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
              retire   = 1'b1;
              state_d  = S_IF;
            end
            CL_MDU: begin
              mdu_start = 1'b1;
              state_d   = S_MDW;
            end
            default: begin
`ifdef MULTICYCLE_CTRL_EXC_EN
              state_d = S_EXC;
`else
              retire  = 1'b1;
              state_d = S_IF;
`endif
            end
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (inst_class == CL_STORE);
          if (dmem_ack) begin
            if (inst_class == CL_STORE) begin
              retire  = 1'b1;
              state_d = S_IF;
            end else begin
              mdr_write = 1'b1;
              state_d   = S_WB;
            end
          end
        end
        S_WB: begin
          rf_write = 1'b1;
          wb_src   = (inst_class == CL_LOAD);
          retire   = 1'b1;
          state_d  = S_IF;
        end
        S_MDW: begin
          if (!mdu_busy) begin
            retire  = 1'b1;
            state_d = S_IF;
          end else if (wd_q == WD_W'(MDU_TIMEOUT - 1)) begin
            wd_hit  = 1'b1;
            state_d = S_IF;
          end
        end
        S_EXC: begin
`ifdef MULTICYCLE_CTRL_EXC_EN
          cp0_write = 1'b1;
          pc_write  = 1'b1;
          pc_src    = 2'b11;
          retire    = 1'b1;
`endif
          state_d   = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  // State, counters and watchdog; the watchdog holds the number of busy MDW cycles already spent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IF;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      wd_q       <= '0;
      mdu_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
      if (state_q == S_MDW && state_d == S_MDW) begin
        wd_q <= wd_q + WD_W'(1);
      end else begin
        wd_q <= '0;
      end
      if (wd_hit) begin
        mdu_err <= 1'b1;
      end
    end
  end

  assign state = 3'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle traces built from the class rules.
// Two instances: default parameters, and CNT_W=4 / MDU_TIMEOUT=8 for wrap and watchdog cases.
module tb_multicycle_ctrl;

  localparam logic [14:0] K_IMEM = 15'h4000;
  localparam logic [14:0] K_DREQ = 15'h2000;
  localparam logic [14:0] K_DWE  = 15'h1000;
  localparam logic [14:0] K_PCW  = 15'h0800;
  localparam logic [14:0] K_IRW  = 15'h0400;
  localparam logic [14:0] K_AW   = 15'h0200;
  localparam logic [14:0] K_BW   = 15'h0100;
  localparam logic [14:0] K_ALUW = 15'h0080;
  localparam logic [14:0] K_MDRW = 15'h0040;
  localparam logic [14:0] K_RFW  = 15'h0020;
  localparam logic [14:0] K_WBS  = 15'h0010;
  localparam logic [14:0] K_PC01 = 15'h0004;
  localparam logic [14:0] K_PC10 = 15'h0008;
  localparam logic [14:0] K_PC11 = 15'h000C;
  localparam logic [14:0] K_MDUS = 15'h0002;
  localparam logic [14:0] K_CP0  = 15'h0001;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [2:0] inst_class;
  logic       branch_taken, imem_ack, dmem_ack, mdu_busy;
  logic       sel;

  logic        a_imem_req, a_dmem_req, a_dmem_we, a_pc_write, a_ir_write, a_a_write, a_b_write;
  logic        a_aluout_write, a_mdr_write, a_rf_write, a_wb_src, a_mdu_start, a_cp0_write, a_mdu_err;
  logic [1:0]  a_pc_src;
  logic [2:0]  a_state;
  logic [31:0] a_cycle, a_retire;

  logic        b_imem_req, b_dmem_req, b_dmem_we, b_pc_write, b_ir_write, b_a_write, b_b_write;
  logic        b_aluout_write, b_mdr_write, b_rf_write, b_wb_src, b_mdu_start, b_cp0_write, b_mdu_err;
  logic [1:0]  b_pc_src;
  logic [2:0]  b_state;
  logic [3:0]  b_cycle, b_retire;

  always #5 clk = ~clk;

  multicycle_ctrl dut_a (
    .clk(clk), .rst(rst_a), .inst_class(inst_class), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mdu_busy(mdu_busy),
    .imem_req(a_imem_req), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we),
    .pc_write(a_pc_write), .ir_write(a_ir_write), .a_write(a_a_write), .b_write(a_b_write),
    .aluout_write(a_aluout_write), .mdr_write(a_mdr_write), .rf_write(a_rf_write),
    .wb_src(a_wb_src), .pc_src(a_pc_src), .mdu_start(a_mdu_start), .cp0_write(a_cp0_write),
    .state(a_state), .cycle_cnt(a_cycle), .retire_cnt(a_retire), .mdu_err(a_mdu_err)
  );

  multicycle_ctrl #(.CNT_W(4), .MDU_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst_b), .inst_class(inst_class), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mdu_busy(mdu_busy),
    .imem_req(b_imem_req), .dmem_req(b_dmem_req), .dmem_we(b_dmem_we),
    .pc_write(b_pc_write), .ir_write(b_ir_write), .a_write(b_a_write), .b_write(b_b_write),
    .aluout_write(b_aluout_write), .mdr_write(b_mdr_write), .rf_write(b_rf_write),
    .wb_src(b_wb_src), .pc_src(b_pc_src), .mdu_start(b_mdu_start), .cp0_write(b_cp0_write),
    .state(b_state), .cycle_cnt(b_cycle), .retire_cnt(b_retire), .mdu_err(b_mdu_err)
  );

  logic [14:0] a_ctrl, b_ctrl, obs_ctrl;
  logic [2:0]  obs_state;
  logic [31:0] obs_cycle, obs_retire;
  logic        obs_err;

  assign a_ctrl = {a_imem_req, a_dmem_req, a_dmem_we, a_pc_write, a_ir_write, a_a_write, a_b_write,
                   a_aluout_write, a_mdr_write, a_rf_write, a_wb_src, a_pc_src, a_mdu_start, a_cp0_write};
  assign b_ctrl = {b_imem_req, b_dmem_req, b_dmem_we, b_pc_write, b_ir_write, b_a_write, b_b_write,
                   b_aluout_write, b_mdr_write, b_rf_write, b_wb_src, b_pc_src, b_mdu_start, b_cp0_write};
  assign obs_ctrl   = sel ? b_ctrl : a_ctrl;
  assign obs_state  = sel ? b_state : a_state;
  assign obs_cycle  = sel ? 32'(b_cycle) : a_cycle;
  assign obs_retire = sel ? 32'(b_retire) : a_retire;
  assign obs_err    = sel ? b_mdu_err : a_mdu_err;

  int          total = 0;
  int          bad = 0;
  int unsigned m_cycle, m_retire, m_mask, m_to;
  bit          m_err;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [2:0] c, input logic ia, input logic da, input logic mb, input logic bt);
    inst_class   = c;
    imem_ack     = ia;
    dmem_ack     = da;
    mdu_busy     = mb;
    branch_taken = bt;
  endtask

  task automatic model_reset();
    m_cycle  = 0;
    m_retire = 0;
    m_err    = 1'b0;
  endtask

  // One clock of the trace: check everything mid-cycle, then advance the model at the edge.
  task automatic cyc(input logic [2:0] est, input logic [14:0] ectl, input bit ret, input bit eset,
                     input string tag);
    @(negedge clk);
    chk({tag, "_state"}, 32'(obs_state), 32'(est));
    chk({tag, "_ctl"}, 32'(obs_ctrl), 32'(ectl));
    chk({tag, "_cycle"}, obs_cycle, m_cycle & m_mask);
    chk({tag, "_retire"}, obs_retire, m_retire & m_mask);
    chk({tag, "_err"}, 32'(obs_err), 32'(m_err));
    @(posedge clk);
    #1;
    m_cycle++;
    if (ret) m_retire++;
    if (eset) m_err = 1'b1;
  endtask

  task automatic run_instr(input logic [2:0] cls, input int iw, input int dw, input int bz, input logic tk);
    logic [14:0] we;
    logic        busy;
    for (int i = 0; i < iw; i++) begin
      drv(3'($urandom), 1'b0, rb(), rb(), rb());
      cyc(3'd0, K_IMEM, 0, 0, "if_wait");
    end
    drv(3'($urandom), 1'b1, rb(), rb(), rb());
    cyc(3'd0, K_IMEM | K_IRW | K_PCW, 0, 0, "if_ack");
    drv(3'($urandom), rb(), rb(), rb(), rb());
    cyc(3'd1, K_AW | K_BW, 0, 0, "id");
    drv(cls, rb(), rb(), rb(), tk);
    case (cls)
      3'd0, 3'd1: begin
        cyc(3'd2, K_ALUW, 0, 0, "ex_alu");
        drv(cls, rb(), rb(), rb(), rb());
        cyc(3'd4, K_RFW, 1, 0, "wb_alu");
      end
      3'd2, 3'd3: begin
        cyc(3'd2, K_ALUW, 0, 0, "ex_mem");
        we = (cls == 3'd3) ? K_DWE : 15'h0;
        for (int i = 0; i < dw; i++) begin
          drv(cls, rb(), 1'b0, rb(), rb());
          cyc(3'd3, K_DREQ | we, 0, 0, "mem_wait");
        end
        drv(cls, rb(), 1'b1, rb(), rb());
        if (cls == 3'd2) begin
          cyc(3'd3, K_DREQ | K_MDRW, 0, 0, "mem_ld");
          drv(cls, rb(), rb(), rb(), rb());
          cyc(3'd4, K_RFW | K_WBS, 1, 0, "wb_ld");
        end else begin
          cyc(3'd3, K_DREQ | K_DWE, 1, 0, "mem_st");
        end
      end
      3'd4: cyc(3'd2, K_ALUW | K_PC01 | (tk ? K_PCW : 15'h0), 1, 0, "ex_br");
      3'd5: cyc(3'd2, K_ALUW | K_PCW | K_PC10, 1, 0, "ex_j");
      3'd6: begin
        cyc(3'd2, K_ALUW | K_MDUS, 0, 0, "ex_mdu");
        // k-th MDW cycle: done if busy has dropped, watchdog fires on the m_to-th busy cycle
        for (int k = 1; k <= int'(m_to); k++) begin
          busy = (k <= bz);
          drv(cls, rb(), rb(), busy, rb());
          if (!busy) begin
            cyc(3'd5, 15'h0, 1, 0, "mdw_done");
            break;
          end else if (k == int'(m_to)) begin
            cyc(3'd5, 15'h0, 0, 1, "mdw_timeout");
          end else begin
            cyc(3'd5, 15'h0, 0, 0, "mdw_busy");
          end
        end
      end
      default: begin
`ifdef MULTICYCLE_CTRL_EXC_EN
        cyc(3'd2, K_ALUW, 0, 0, "ex_exc");
        drv(cls, rb(), rb(), rb(), rb());
        cyc(3'd6, K_CP0 | K_PCW | K_PC11, 1, 0, "exc");
`else
        cyc(3'd2, K_ALUW, 1, 0, "ex_exc_nop");
`endif
      end
    endcase
  endtask

  initial begin
    int unsigned r_before;
    sel    = 1'b0;
    m_mask = 32'hFFFF_FFFF;
    m_to   = 64;
    model_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    drv(3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(obs_state), 32'd0);
    chk("rst_ctl", 32'(obs_ctrl), 32'(K_IMEM));
    chk("rst_cycle", obs_cycle, 32'd0);
    chk("rst_retire", obs_retire, 32'd0);
    chk("rst_err", 32'(obs_err), 32'd0);
    rst_a = 1'b1;

    run_instr(3'd0, 0, 0, 0, 1'b0);
    chk("alu_r_cycles", obs_cycle, 32'd4);
    chk("alu_r_retired", obs_retire, 32'd1);
    run_instr(3'd2, 0, 2, 0, 1'b0);
    chk("load_cycles", obs_cycle, 32'd11);
    chk("load_retired", obs_retire, 32'd2);
    run_instr(3'd4, 0, 0, 0, 1'b0);
    run_instr(3'd4, 0, 0, 0, 1'b1);
    chk("branch_cycles", obs_cycle, 32'd17);
    run_instr(3'd6, 0, 0, 10, 1'b0);
    chk("mdu_cycles", obs_cycle, 32'd31);
    run_instr(3'd7, 0, 0, 0, 1'b0);
    run_instr(3'd3, 0, 1, 0, 1'b0);
    run_instr(3'd5, 0, 0, 0, 1'b0);
    run_instr(3'd1, 2, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      run_instr(3'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 12)), rb());
    end

    // Abort a LOAD while it waits in MEM
    drv(3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(3'd0, K_IMEM | K_IRW | K_PCW, 0, 0, "ab_if");
    drv(3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3'd1, K_AW | K_BW, 0, 0, "ab_id");
    cyc(3'd2, K_ALUW, 0, 0, "ab_ex");
    cyc(3'd3, K_DREQ, 0, 0, "ab_mem");
    #2;
    imem_ack = 1'b1;
    rst_a = 1'b0;
    #1;
    model_reset();
    chk("abort_state", 32'(obs_state), 32'd0);
    chk("abort_ctl", 32'(obs_ctrl), 32'(K_IMEM));
    chk("abort_cycle", obs_cycle, 32'd0);
    chk("abort_retire", obs_retire, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_hold_cycle", obs_cycle, 32'd0);
    rst_a = 1'b1;
    run_instr(3'd0, 0, 0, 0, 1'b0);
    chk("post_abort_retired", obs_retire, 32'd1);

    // Small instance: counter wrap and MDU watchdog
    rst_a  = 1'b0;
    sel    = 1'b1;
    m_mask = 32'h0000_000F;
    m_to   = 8;
    model_reset();
    rst_b = 1'b1;
    for (int n = 0; n < 16; n++) begin
      run_instr((n % 2 == 0) ? 3'd5 : 3'd0, int'($urandom_range(0, 1)), 0, 0, 1'b0);
    end
    chk("wrap_retire", obs_retire, 32'd0);
    run_instr(3'd6, 0, 0, 7, 1'b0);
    chk("mdu_edge_retire", obs_retire, 32'd1);
    chk("mdu_edge_err", 32'(obs_err), 32'd0);
    r_before = m_retire;
    run_instr(3'd6, 0, 0, 1000, 1'b0);
    chk("timeout_err", 32'(obs_err), 32'd1);
    chk("timeout_noretire", obs_retire, r_before & 32'hF);
    for (int n = 0; n < 30; n++) begin
      run_instr(3'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 12)), rb());
    end
    chk("err_sticky", 32'(obs_err), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("err_cleared", 32'(obs_err), 32'd0);
    chk("b_rst_state", 32'(obs_state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
